fpu_issue_ctrl: RTL

//  Shares one FPU datapath (fp32/fp16, 2-bit op) between two requesters, e.g. core issue and a loop/vector unit.

---
 rtl/fpu_ctrl_pkg.sv | 15 +
 rtl/fpu_rr_arb2.sv | 16 +
 rtl/fpu_issue_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fpu_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: FSM encoding, op-field bit positions
// and the width of the latency counter.
package fpu_ctrl_pkg;

    localparam int CNT_W       = 4;
    localparam int OP_FP32_BIT = 0;
    localparam int OP_SEL_BIT  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } fpu_state_e;

endpackage

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// When both requesters are valid, the one that did not win last time is granted.
module fpu_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Shares one multicycle FPU between two requesters with round-robin arbitration.
// Only one op is in flight; the registered result returns on a valid/ready response port.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic [WIDTH-1:0] fpu_a,
    output logic [WIDTH-1:0] fpu_b,
    output logic [1:0]       fpu_ctrl,
    input  logic [WIDTH-1:0] fpu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             busy,
    output fpu_state_e       dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [WIDTH-1:0] FP16_MASK = WIDTH'(16'hFFFF);

    fpu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_last_q, rr_last_d;
    logic [WIDTH-1:0] fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
    logic [1:0]       fpu_ctrl_q, fpu_ctrl_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [1:0]       grant;
    logic             accept;
    logic             sel_id;

    fpu_rr_arb2 u_arb (
        .valid (({req1_valid, req0_valid})),
        .last  (rr_last_q),
        .grant (grant)
    );

    // A transfer happens on a rising edge where valid and ready are both high; ready is
    // combinational from valid, state and reset only, and valid/payload must hold until then.
    always_comb begin
        req0_ready = reset && (state_q == IDLE) && grant[0];
        req1_ready = reset && (state_q == IDLE) && grant[1];
        accept     = req0_ready || req1_ready;
        sel_id     = grant[1];
        busy       = (state_q != IDLE);
        fpu_a      = fpu_a_q;
        fpu_b      = fpu_b_q;
        fpu_ctrl   = fpu_ctrl_q;
        rsp_valid  = rsp_valid_q;
        rsp_id     = rsp_id_q;
        rsp_result = rsp_result_q;
        dbg_state  = state_q;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_last_d    = rr_last_q;
        fpu_a_d      = fpu_a_q;
        fpu_b_d      = fpu_b_q;
        fpu_ctrl_d   = fpu_ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    fpu_a_d    = sel_id ? req1_a  : req0_a;
                    fpu_b_d    = sel_id ? req1_b  : req0_b;
                    fpu_ctrl_d = sel_id ? req1_op : req0_op;
                    rsp_id_d   = sel_id;
                    rr_last_d  = sel_id;
                    cnt_d      = CNT_LOAD;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // Operands stay frozen here so the FPU sees a stable multicycle path.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_result_d = fpu_ctrl_q[OP_FP32_BIT] ? fpu_result
                                                           : (fpu_result & FP16_MASK);
                    rsp_valid_d  = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_last_q    <= 1'b1;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            fpu_ctrl_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_last_q    <= rr_last_d;
            fpu_a_q      <= fpu_a_d;
            fpu_b_q      <= fpu_b_d;
            fpu_ctrl_q   <= fpu_ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

endmodule
